// File: rtl/rpp_hdr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpp_hdr_pkg
// Description : Shared constants and types for the RPP header assembler.
// Revision    : 1.0 - initial release
// ============================================================================
package rpp_hdr_pkg;
    localparam int HDR_BYTES = 18;
    localparam int HDR_W     = 8 * HDR_BYTES;

    // Byte offsets of each header field, byte 0 is the first byte on the wire
    localparam int OFF_RPP      = 0;
    localparam int OFF_PKT_ID   = 2;
    localparam int OFF_ORIGIN   = 6;
    localparam int OFF_CONSENT  = 8;
    localparam int OFF_ENTROPY  = 10;
    localparam int OFF_PAYLOAD  = 11;
    localparam int OFF_FALLBACK = 12;
    localparam int OFF_WID      = 13;
    localparam int OFF_PHASE    = 14;
    localparam int OFF_CRC      = 17;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/rpp_crc8_byte.sv
`default_nettype none
// ============================================================================
// Module      : rpp_crc8_byte
// Description : Combinational CRC-8 update over one byte, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module rpp_crc8_byte #(
    parameter logic [7:0] CRC_POLY = rpp_hdr_pkg::CRC_POLY
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);
    logic [7:0] w_crc;

    always_comb begin
        w_crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            w_crc = {w_crc[6:0], 1'b0} ^ ((w_crc[7] ^ data_in[7-i]) ? CRC_POLY : 8'h00);
        end
    end

    assign crc_out = w_crc;
endmodule
`default_nettype wire

// File: rtl/rpp_header_assembler.sv
`default_nettype none
// ============================================================================
// Module      : rpp_header_assembler
// Description : Collects the 18-byte RPP header from a byte stream and holds
//               it with a valid/ready handshake. CRC-8 checking is built only
//               when RPP_HDR_CRC_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rpp_header_assembler #(
    parameter int HDR_BYTES = rpp_hdr_pkg::HDR_BYTES,
    parameter int CNT_W     = 8
`ifdef RPP_HDR_CRC_CHECK_EN
   ,parameter logic [7:0] CRC_POLY = rpp_hdr_pkg::CRC_POLY,
    parameter logic [7:0] CRC_INIT = rpp_hdr_pkg::CRC_INIT
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_sof,
    output logic                   in_ready,
    output logic [8*HDR_BYTES-1:0] hdr_out,
    output logic                   hdr_valid,
    input  logic                   hdr_ready,
    output logic                   crc_ok,
    output logic [CNT_W-1:0]       abort_cnt,
    output logic [CNT_W-1:0]       crc_err_cnt
);
    import rpp_hdr_pkg::*;

    localparam int                  c_hdr_w    = 8 * HDR_BYTES;
    localparam int                  c_idx_w    = $clog2(HDR_BYTES + 1);
    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(HDR_BYTES - 1);
    localparam logic [c_idx_w-1:0]  c_one      = c_idx_w'(1);

    state_t               r_state;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_hdr_w-1:0]   r_hdr;
    logic                 r_hdr_valid;
    logic                 r_crc_ok;
    logic [CNT_W-1:0]     r_abort_cnt;
    logic                 w_accept;
    logic                 w_crc_match;

    assign in_ready = (r_state != HOLD);
    assign w_accept = in_valid && in_ready;

`ifdef RPP_HDR_CRC_CHECK_EN
    logic [7:0]       r_crc;
    logic [7:0]       w_crc_seed;
    logic [7:0]       w_crc_next;
    logic [CNT_W-1:0] r_crc_err_cnt;

    // A sof byte always restarts the CRC, both in IDLE and on an abort
    assign w_crc_seed  = in_sof ? CRC_INIT : r_crc;
    assign w_crc_match = (in_data == r_crc);

    rpp_crc8_byte #(
        .CRC_POLY (CRC_POLY)
    ) u_crc8 (
        .crc_in  (w_crc_seed),
        .data_in (in_data),
        .crc_out (w_crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc         <= CRC_INIT;
            r_crc_err_cnt <= '0;
        end else begin
            if (w_accept && (in_sof || r_state == COLLECT)) begin
                r_crc <= w_crc_next;
            end
            if (r_state == HOLD && hdr_ready && !r_crc_ok && r_crc_err_cnt != '1) begin
                r_crc_err_cnt <= r_crc_err_cnt + 1'b1;
            end
        end
    end

    assign crc_err_cnt = r_crc_err_cnt;
`else
    assign w_crc_match = 1'b1;
    assign crc_err_cnt = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_hdr       <= '0;
            r_hdr_valid <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_abort_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && in_sof) begin
                        r_hdr   <= {r_hdr[c_hdr_w-9:0], in_data};
                        r_idx   <= c_one;
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_accept) begin
                        r_hdr <= {r_hdr[c_hdr_w-9:0], in_data};
                        if (in_sof) begin
                            r_idx <= c_one;
                            if (r_abort_cnt != '1) begin
                                r_abort_cnt <= r_abort_cnt + 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            if (r_idx == c_last_idx) begin
                                r_hdr_valid <= 1'b1;
                                r_crc_ok    <= w_crc_match;
                                r_state     <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hdr_ready) begin
                        r_hdr_valid <= 1'b0;
                        r_crc_ok    <= 1'b0;
                        r_idx       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hdr_out   = r_hdr;
    assign hdr_valid = r_hdr_valid;
    assign crc_ok    = r_crc_ok;
    assign abort_cnt = r_abort_cnt;
endmodule
`default_nettype wire
